// File: rtl/ps2_key_pkg.sv
// Shared PS/2 set-2 scan-code constants and decoder state encoding.
package ps2_key_pkg;

  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_key_decoder_pulse_stretch.sv
// Stretches a one-cycle trigger into a level held for STATUS_HOLD cycles;
// a trigger during the hold reloads the full count.
module pulse_stretch #(
  parameter int STATUS_HOLD = 1000
) (
  input  logic clock,
  input  logic resetn,
  input  logic trigger,
  output logic level
);

  localparam int CNT_W = $clog2(STATUS_HOLD + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = CNT_W'(STATUS_HOLD);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    level_d = (cnt_d != '0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: tracks held arrow/A/D keys and stretches Enter
// presses into a game_status level for the register file.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int STATUS_HOLD    = 1000,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       move_left,
  output logic       move_right,
  output logic       game_status,
  output logic [1:0] dbg_state
);

  localparam int TO_W = $clog2(PREFIX_TIMEOUT + 1);

  ps2_state_e      state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            left_q, left_d, a_q, a_d, right_q, right_d, d_q, d_d;
  logic            move_left_q, move_left_d, move_right_q, move_right_d;
  logic            is_ext, is_brk, enter_make;

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    left_d     = left_q;
    a_d        = a_q;
    right_d    = right_q;
    d_d        = d_q;
    enter_make = 1'b0;
    is_ext     = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    is_brk     = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    if (ps2_key_pressed) begin
      to_cnt_d = '0;
      if (ps2_key_data == KEY_EXT) begin
        state_d = ST_EXT;
      end else if (ps2_key_data == KEY_BRK) begin
        state_d = is_ext ? ST_EXT_BRK : ST_BRK;
      end else begin
        // Final byte of a sequence: extended and plain codes live in
        // separate namespaces, so E0 1C never aliases A.
        state_d = ST_IDLE;
        if (is_ext) begin
          case (ps2_key_data)
            KEY_LEFT:  left_d  = !is_brk;
            KEY_RIGHT: right_d = !is_brk;
            default:   ;
          endcase
        end else begin
          case (ps2_key_data)
            KEY_A:     a_d        = !is_brk;
            KEY_D:     d_d        = !is_brk;
            KEY_ENTER: enter_make = !is_brk;
            default:   ;
          endcase
        end
      end
    end else if (state_q != ST_IDLE) begin
      // An abandoned prefix falls back to IDLE without touching held keys.
      if (to_cnt_q == TO_W'(PREFIX_TIMEOUT - 1)) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end

    move_left_d  = left_d | a_d;
    move_right_d = right_d | d_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      to_cnt_q     <= '0;
      left_q       <= 1'b0;
      a_q          <= 1'b0;
      right_q      <= 1'b0;
      d_q          <= 1'b0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      left_q       <= left_d;
      a_q          <= a_d;
      right_q      <= right_d;
      d_q          <= d_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
    end
  end

  pulse_stretch #(
    .STATUS_HOLD(STATUS_HOLD)
  ) u_status (
    .clock  (clock),
    .resetn (resetn),
    .trigger(enter_make),
    .level  (game_status)
  );

  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random byte streams,
// checked every cycle against a sequence-level reference model.
module tb_ps2_key_decoder;

  localparam int HOLD = 4;
  localparam int TMO  = 10;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       ps2_key_pressed = 1'b0;
  logic       move_left, move_right, game_status;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  ps2_key_decoder #(
    .STATUS_HOLD   (HOLD),
    .PREFIX_TIMEOUT(TMO)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ps2_key_data   (ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed),
    .move_left      (move_left),
    .move_right     (move_right),
    .game_status    (game_status),
    .dbg_state      (dbg_state)
  );

  always #5 clock = ~clock;

  // Reference model: pending prefix bytes, held keys, time of last Enter.
  logic [7:0] prefix_q[$];
  logic [2:0] exp_q[$];
  int  idle_cnt = 0;
  int  cyc = 0;
  int  last_enter = -1000;
  bit  h_left = 0, h_a = 0, h_right = 0, h_d = 0;

  function automatic bit prefix_has(input logic [7:0] b);
    foreach (prefix_q[i]) if (prefix_q[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] model_out();
    logic gs;
    gs = (cyc - last_enter) < HOLD;
    return {gs, h_left | h_a, h_right | h_d};
  endfunction

  task automatic model_reset();
    prefix_q.delete();
    idle_cnt   = 0;
    last_enter = -1000;
    h_left = 0; h_a = 0; h_right = 0; h_d = 0;
  endtask

  task automatic model_step(input logic p, input logic [7:0] d);
    bit ext, brk;
    cyc++;
    if (p) begin
      idle_cnt = 0;
      if (d == 8'hE0) begin
        prefix_q.delete();
        prefix_q.push_back(8'hE0);
      end else if (d == 8'hF0) begin
        if (!prefix_has(8'hF0)) prefix_q.push_back(8'hF0);
      end else begin
        ext = prefix_has(8'hE0);
        brk = prefix_has(8'hF0);
        prefix_q.delete();
        if (ext) begin
          if (d == 8'h6B) h_left  = !brk;
          if (d == 8'h74) h_right = !brk;
        end else begin
          if (d == 8'h1C) h_a = !brk;
          if (d == 8'h23) h_d = !brk;
          if (d == 8'h5A && !brk) last_enter = cyc;
        end
      end
    end else if (prefix_q.size() != 0) begin
      idle_cnt++;
      if (idle_cnt >= TMO) begin
        prefix_q.delete();
        idle_cnt = 0;
      end
    end
  endtask

  task automatic drive_cycle(input logic p, input logic [7:0] d);
    @(negedge clock);
    resetn          = 1'b1;
    ps2_key_pressed = p;
    ps2_key_data    = p ? d : 8'($urandom);
    model_step(p, d);
    exp_q.push_back(model_out());
  endtask

  task automatic strobe(input logic [7:0] d);
    drive_cycle(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      resetn          = 1'b0;
      ps2_key_pressed = 1'b0;
      cyc++;
      model_reset();
      exp_q.push_back(3'b000);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected {game_status, move_left, move_right} per cycle.
  always @(posedge clock) begin
    logic [2:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({game_status, move_left, move_right} !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d actual gs/ml/mr=%b required=%b",
                 cyc, {game_status, move_left, move_right}, e);
      end
    end
  end

  logic [7:0] code_tbl[11];
  int hi;

  initial begin
    code_tbl = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C, 8'h23, 8'h5A,
                 8'hE1, 8'h14, 8'h77, 8'h00};

    do_reset(3);
    idle(1);
    chk("reset_ml", {7'd0, move_left}, 8'd0);
    chk("reset_mr", {7'd0, move_right}, 8'd0);
    chk("reset_gs", {7'd0, game_status}, 8'd0);

    // Left arrow make then break.
    strobe(8'hE0); strobe(8'h6B); idle(1);
    chk("left_make", {7'd0, move_left}, 8'd1);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h6B); idle(1);
    chk("left_break", {7'd0, move_left}, 8'd0);

    // A and Left overlap: releasing A keeps move_left high.
    strobe(8'h1C); strobe(8'hE0); strobe(8'h6B);
    strobe(8'hF0); strobe(8'h1C); idle(1);
    chk("a_rel_left_held", {7'd0, move_left}, 8'd1);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h6B); idle(1);
    chk("left_rel", {7'd0, move_left}, 8'd0);

    // D + Right, then A: both outputs high.
    strobe(8'h23); strobe(8'hE0); strobe(8'h74); idle(1);
    chk("right_on", {7'd0, move_right}, 8'd1);
    chk("left_unchanged", {7'd0, move_left}, 8'd0);
    strobe(8'h1C); idle(1);
    chk("both_on", {6'd0, move_left, move_right}, 8'd3);
    strobe(8'hF0); strobe(8'h1C);
    strobe(8'hF0); strobe(8'h23);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h74); idle(1);
    chk("all_released", {6'd0, move_left, move_right}, 8'd0);

    // Enter stretch, reload, keypad Enter.
    idle(HOLD + 2);
    strobe(8'h5A);
    hi = 0;
    for (int i = 0; i < 8; i++) begin idle(1); hi += int'(game_status); end
    chk("enter_len", 8'(hi), 8'(HOLD));
    strobe(8'h5A); idle(1); strobe(8'h5A);
    hi = 0;
    for (int i = 0; i < 8; i++) begin idle(1); hi += int'(game_status); end
    chk("enter_reload_len", 8'(hi), 8'(HOLD));
    strobe(8'hE0); strobe(8'h5A);
    hi = 0;
    for (int i = 0; i < 8; i++) begin idle(1); hi += int'(game_status); end
    chk("kp_enter_none", 8'(hi), 8'd0);
    strobe(8'hF0); strobe(8'h5A);
    hi = 0;
    for (int i = 0; i < 6; i++) begin idle(1); hi += int'(game_status); end
    chk("enter_break_none", 8'(hi), 8'd0);

    // Prefix timeout: 6B after an abandoned E0 is plain and unmapped.
    strobe(8'hE0); idle(TMO); strobe(8'h6B); idle(1);
    chk("timeout_ml", {7'd0, move_left}, 8'd0);
    chk("timeout_state", {6'd0, dbg_state}, 8'd0);

    // Reset mid-sequence with move_right held.
    strobe(8'hE0); strobe(8'h74); strobe(8'hE0); strobe(8'hF0);
    do_reset(2);
    chk("rst_outputs", {5'd0, game_status, move_left, move_right}, 8'd0);
    strobe(8'h74); idle(1);
    chk("post_rst_74", {7'd0, move_right}, 8'd0);

    // Random byte streams with occasional long gaps and resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 2));
      strobe(code_tbl[$urandom_range(0, 10)]);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(8, 14));
      else idle($urandom_range(0, 2));
    end

    idle(2);
    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter STATUS_HOLD, default 1000, cycles game_status stays high after an Enter press.
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 100000, idle cycles after a prefix byte before the prefix is abandoned.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_key_data  input  8  received PS/2 scan-code byte, valid only when ps2_key_pressed=1.
REQ-006 SHALL have port ps2_key_pressed  input  1  one-cycle strobe: new byte on ps2_key_data.
REQ-007 SHALL have port move_left  output  1  level, high while Left-arrow or A is held; feeds the regfile read of register 1.
REQ-008 SHALL have port move_right  output  1  level, high while Right-arrow or D is held; feeds the regfile read of register 2.
REQ-009 SHALL have port game_status  output  1  stretched pulse after Enter make; feeds the regfile read of register 3.

Function
REQ-010 SHALL decode PS/2 set-2 codes: Left = E0 6B, Right = E0 74, A = 1C, D = 23, Enter = 5A (non-extended); break = F0 before the code (after E0 if extended).
REQ-011 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-012 SHALL transition IDLE->EXT on E0, IDLE->BRK on F0, EXT->EXT_BRK on F0; any other byte in IDLE/EXT is a make code and returns to IDLE; any byte in BRK/EXT_BRK is a break code and returns to IDLE.
REQ-013 SHALL treat E0 received in EXT/BRK/EXT_BRK as restarting the sequence (go to EXT), and F0 received in BRK/EXT_BRK as staying in that state.
REQ-014 SHALL keep four held flags (left_arrow, a_key, right_arrow, d_key): set on matching make, clear on matching break, in the cycle after the strobe.
REQ-015 SHALL match extended codes only in EXT/EXT_BRK and non-extended codes only in IDLE/BRK (E0 1C is not A).
REQ-016 SHALL drive move_left = left_arrow OR a_key and move_right = right_arrow OR d_key, registered; latency one clock from the ps2_key_pressed strobe of the final byte.
REQ-017 SHALL allow move_left and move_right high simultaneously; no arbitration.
REQ-018 SHALL ignore repeated make codes (typematic); a held flag already set stays set.
REQ-019 SHALL ignore unmapped codes (E1 pause sequence included) without altering held flags.
REQ-020 SHALL count clocks while in EXT/BRK/EXT_BRK with no strobe; on reaching PREFIX_TIMEOUT, return to IDLE, flags unchanged; counter clears on every strobe and in IDLE.
REQ-021 SHALL on Enter make (IDLE, 5A) assert game_status the next cycle for exactly STATUS_HOLD cycles; a new Enter make during the hold reloads the count to STATUS_HOLD.
REQ-022 SHALL not assert game_status on Enter break or on E0 5A (keypad Enter).
REQ-023 SHALL ignore ps2_key_data when ps2_key_pressed=0.

Reset
REQ-024 SHALL, while resetn=0, force FSM to IDLE, all held flags to 0, move_left=0, move_right=0, game_status=0, both counters to 0.
REQ-025 SHALL discard any partial prefix sequence when reset asserts mid-sequence; the first byte after release is decoded from IDLE.

Structure
REQ-026 SHALL place scan-code constants (E0, F0, 6B, 74, 1C, 23, 5A) and the FSM state encoding in shared package ps2_key_pkg.
REQ-027 SHALL implement the game_status hold counter as sub-module pulse_stretch (parameter STATUS_HOLD; inputs clock, resetn, trigger; output level).
REQ-028 SHALL size counters as $clog2(parameter+1) bits with no wrap-around.

Verification
REQ-029 SHALL cover: strobes E0,6B -> move_left=1 one cycle after second strobe; then E0,F0,6B -> move_left=0.
REQ-030 SHALL cover: 1C make then E0 6B make, then F0 1C -> move_left stays 1 until E0 F0 6B.
REQ-031 SHALL cover: 23 make with E0 74 make -> move_right=1 and move_left unchanged; 1C make -> both outputs 1.
REQ-032 SHALL cover: 5A with STATUS_HOLD=4 -> game_status high exactly 4 cycles; second 5A at cycle 2 -> high 4 cycles from reload; E0 5A -> no pulse.
REQ-033 SHALL cover: E0 then PREFIX_TIMEOUT=10 idle cycles then 6B -> A/left unaffected, 6B treated as unmapped non-extended, move_left=0.
REQ-034 SHALL cover: resetn pulsed low after E0 F0 while move_right=1 -> all outputs 0; subsequent 74 alone does nothing.
